// File: rtl/usart_rx_ctrl.sv
// usart_rx_ctrl: receive-side control for a USART.
// Synchronises the receiver's byte-valid and framing-error levels.
// Acknowledges each event with a four-phase rx_ready handshake.
// Buffers received bytes in a first-word-fall-through FIFO.
// Tracks overrun and framing-error status.
// Drives a hysteretic RTS flow-control output from the FIFO fill level.
//
// Handshake semantics:
// - Receiver side, four-phase: rx_valid/rx_error are levels held until
//   rx_ready rises. rx_ready stays high until both levels are seen low,
//   then drops.
// - Consumer side: a byte moves when rd_valid && rd_ready on a rising edge.
//   rd_data is valid only while rd_valid is high.
module usart_rx_ctrl #(
    parameter int DEPTH    = 8,
    parameter int RTS_HIGH = 6,
    parameter int RTS_LOW  = 2
) (
    input  logic                     serial_clock,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_error,
    output logic                     rx_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic [7:0]               frame_errors,
    input  logic                     clear_status,
    output logic                     rts_out,
    output logic [1:0]               dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] RTS_HIGH_C = CW'(RTS_HIGH);
    localparam logic [CW-1:0] RTS_LOW_C  = CW'(RTS_LOW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            sv_meta_q, sv_q, se_meta_q, se_q;
    logic            rx_ready_q;
    logic            push_req, fe_inc;
    logic            pop, push, drop, full;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic            overrun_q, overrun_d;
    logic [7:0]      fe_q, fe_d;
    logic            rts_q, rts_d;

    // Two-flop synchronisers for the asynchronous receiver levels
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            sv_meta_q <= 1'b0;
            sv_q      <= 1'b0;
            se_meta_q <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            sv_meta_q <= rx_valid;
            sv_q      <= sv_meta_q;
            se_meta_q <= rx_error;
            se_q      <= se_meta_q;
        end
    end

    // Handshake FSM next-state logic; a byte takes priority over an error
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        fe_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sv_q) begin
                    state_d = CAPTURE;
                end else if (se_q) begin
                    state_d = ACK;
                    fe_inc  = 1'b1;
                end
            end
            CAPTURE: begin
                push_req = 1'b1;
                state_d  = ACK;
            end
            ACK: begin
                if (!sv_q && !se_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered acknowledge (high exactly while in ACK)
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= (state_d == ACK);
        end
    end

    // FIFO control; a pop in the same cycle frees the slot a full push needs
    always_comb begin
        full     = (count_q == DEPTH_C);
        pop      = rd_ready && (count_q != '0);
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and fill level
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are not reset
    always_ff @(posedge serial_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Status and flow-control next values; set/increment beats clear
    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_status) begin
            overrun_d = 1'b0;
        end

        fe_d = fe_q;
        if (fe_inc) begin
            fe_d = (fe_q == 8'hFF) ? fe_q : fe_q + 8'd1;
        end else if (clear_status) begin
            fe_d = 8'd0;
        end

        rts_d = rts_q;
        if (count_q >= RTS_HIGH_C) begin
            rts_d = 1'b1;
        end else if (count_q <= RTS_LOW_C) begin
            rts_d = 1'b0;
        end
    end

    // Status and flow-control registers
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            overrun_q <= 1'b0;
            fe_q      <= 8'd0;
            rts_q     <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            fe_q      <= fe_d;
            rts_q     <= rts_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign rd_data      = mem_q[rd_ptr_q];
    assign rd_valid     = (count_q != '0);
    assign count        = count_q;
    assign overrun      = overrun_q;
    assign frame_errors = fe_q;
    assign rts_out      = rts_q;
    assign dbg_state_o  = state_q;

endmodule
